// File: rtl/sd_sector_arbiter.sv
// Two-requester arbiter in front of a single SD sector reader.
// Grants alternate under contention, forwards the reader byte stream to the grantee, and checks its ordering.
module sd_sector_arbiter #(
  parameter int SECTOR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic [SECTOR_W-1:0] sector0,
  input  logic [SECTOR_W-1:0] sector1,
  output logic                ack0,
  output logic                ack1,
  output logic                done0,
  output logic                done1,
  output logic                err0,
  output logic                err1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [8:0]          raddr0,
  output logic [8:0]          raddr1,
  output logic [7:0]          rdata0,
  output logic [7:0]          rdata1,
  output logic                rd_start,
  output logic [SECTOR_W-1:0] rd_sector_no,
  input  logic                rd_done,
  input  logic                rd_rvalid,
  input  logic [8:0]          rd_raddr,
  input  logic [7:0]          rd_rdata,
  output logic                busy,
  output logic                owner,
  output logic [1:0]          fsm_state
);

  // Handshake: reqN is a level held by the requester; ackN pulses once in the
  // first BUSY cycle; doneN (with errN) pulses once in the GAP cycle. rd_start
  // is a level held until the reader's rd_done pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state;
  logic       last_served;
  logic [9:0] beat_cnt;
  logic       err_flag;

  logic       any_req;
  logic       grant_id;
  logic       beat_ok;
  logic [9:0] cnt_final;
  logic       err_final;

  assign fsm_state = state;

  // Under contention the requester that was not served last wins.
  assign any_req   = req0 | req1;
  assign grant_id  = (req0 & req1) ? ~last_served : req1;

  // A beat coincident with rd_done still counts toward the 512-byte total.
  assign beat_ok   = ({1'b0, rd_raddr} == beat_cnt);
  assign cnt_final = beat_cnt + {9'd0, rd_rvalid};
  assign err_final = err_flag | (rd_rvalid & ~beat_ok) | (cnt_final != 10'd512);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_served  <= 1'b1;
      owner        <= 1'b0;
      busy         <= 1'b0;
      rd_start     <= 1'b0;
      rd_sector_no <= '0;
      beat_cnt     <= '0;
      err_flag     <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      raddr0       <= '0;
      raddr1       <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      case (state)
        IDLE: begin
          if (any_req) begin
            state        <= BUSY;
            owner        <= grant_id;
            last_served  <= grant_id;
            rd_sector_no <= grant_id ? sector1 : sector0;
            ack0         <= ~grant_id;
            ack1         <= grant_id;
            rd_start     <= 1'b1;
            busy         <= 1'b1;
            beat_cnt     <= '0;
            err_flag     <= 1'b0;
          end
        end

        BUSY: begin
          if (rd_rvalid) begin
            beat_cnt <= beat_cnt + 10'd1;
            if (!beat_ok) err_flag <= 1'b1;
            if (owner) begin
              rvalid1 <= 1'b1;
              raddr1  <= rd_raddr;
              rdata1  <= rd_rdata;
            end else begin
              rvalid0 <= 1'b1;
              raddr0  <= rd_raddr;
              rdata0  <= rd_rdata;
            end
          end
          if (rd_done) begin
            state    <= GAP;
            rd_start <= 1'b0;
            if (owner) begin
              done1 <= 1'b1;
              err1  <= err_final;
            end else begin
              done0 <= 1'b1;
              err0  <= err_final;
            end
          end
        end

        // One cycle with rd_start low so the reader always sees a fresh start edge.
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rd_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: a reader model feeds beats, each forwarded beat
// and every handshake pulse is checked with immediate assertions against hand-derived values.
module tb_sd_sector_arbiter;

  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [SW-1:0] sector0, sector1;
  logic          ack0, ack1, done0, done1, err0, err1, rvalid0, rvalid1;
  logic [8:0]    raddr0, raddr1;
  logic [7:0]    rdata0, rdata1;
  logic          rd_start;
  logic [SW-1:0] rd_sector_no;
  logic          rd_done, rd_rvalid;
  logic [8:0]    rd_raddr;
  logic [7:0]    rd_rdata;
  logic          busy, owner;
  logic [1:0]    fsm_state;

  int total = 0;
  int bad   = 0;
  int w;

  sd_sector_arbiter #(.SECTOR_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .sector0(sector0), .sector1(sector1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
    .rd_start(rd_start), .rd_sector_no(rd_sector_no), .rd_done(rd_done),
    .rd_rvalid(rd_rvalid), .rd_raddr(rd_raddr), .rd_rdata(rd_rdata),
    .busy(busy), .owner(owner), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] beat_data(input int who, input int a);
    logic [7:0] k;
    k = (who != 0) ? 8'h3c : 8'ha5;
    return 8'(a) ^ k;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_pulses"}, {ack0, ack1, done0, done1, err0, err1, rvalid0, rvalid1}, 0);
    check({tag, "_ctrl"}, {rd_start, busy, owner}, 0);
    check({tag, "_raddr"}, {raddr0, raddr1}, 0);
    check({tag, "_rdata"}, {rdata0, rdata1}, 0);
    check({tag, "_sector"}, rd_sector_no, 0);
    check({tag, "_state"}, fsm_state, 0);
  endtask

  task automatic wait_ack(input int who, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(ack0 | ack1) && waited < 16);
    check("ack_seen", ack0 | ack1, 1);
    check("ack0_who", ack0, who == 0);
    check("ack1_who", ack1, who == 1);
  endtask

  // Runs one transaction; skip >= 0 omits that address; abort_at >= 0 resets mid-stream.
  task automatic do_txn(input int who, input logic [SW-1:0] sec, input int skip,
                        input logic [1:0] drop, input bit exp_err, input int abort_at,
                        output int waited);
    int a;
    int nb;
    wait_ack(who, waited);
    check("owner", owner, who);
    check("sector", rd_sector_no, sec);
    check("start_hi", rd_start, 1);
    check("busy_hi", busy, 1);
    check("rvalid_pre", rvalid0 | rvalid1, 0);
    if (drop[0]) req0 = 1'b0;
    if (drop[1]) req1 = 1'b0;
    nb = (skip >= 0) ? 511 : 512;
    a = 0;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        rd_rvalid = 1'b0;
        rd_done   = 1'b0;
        tick();
        check_quiet("abort_hold");
        rst_n = 1'b1;
        return;
      end
      if (a == skip) a++;
      rd_rvalid = 1'b1;
      rd_raddr  = 9'(a);
      rd_rdata  = beat_data(who, a);
      rd_done   = (b == nb - 1);
      tick();
      check("rvalid_own", (who != 0) ? rvalid1 : rvalid0, 1);
      check("rvalid_other", (who != 0) ? rvalid0 : rvalid1, 0);
      check("raddr", (who != 0) ? raddr1 : raddr0, a);
      check("rdata", (who != 0) ? rdata1 : rdata0, beat_data(who, a));
      check("ack_one_pulse", ack0 | ack1, 0);
      if (b == nb - 1) begin
        check("done_own", (who != 0) ? done1 : done0, 1);
        check("done_other", (who != 0) ? done0 : done1, 0);
        check("err_own", (who != 0) ? err1 : err0, exp_err);
        check("err_other", (who != 0) ? err0 : err1, 0);
        check("gap_start_lo", rd_start, 0);
        check("gap_busy_hi", busy, 1);
        check("gap_state", fsm_state, 2);
      end else begin
        check("done_early", done0 | done1, 0);
      end
      a++;
    end
    rd_rvalid = 1'b0;
    rd_done   = 1'b0;
    rd_raddr  = '0;
    tick();
    check("post_pulses", {done0, done1, err0, err1, rvalid0, rvalid1}, 0);
    check("post_busy", busy, 0);
    check("post_start", rd_start, 0);
    check("post_state", fsm_state, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    sector0 = '0; sector1 = '0;
    rd_done = 1'b0; rd_rvalid = 1'b0; rd_raddr = '0; rd_rdata = '0;
    #1;
    check_quiet("reset");
    repeat (2) tick();
    check_quiet("reset_held");
    rst_n = 1'b1;
    tick();
    check_quiet("idle");

    // Single requester 0, clean 512-byte sector.
    sector0 = 32'h10; req0 = 1'b1;
    do_txn(0, 32'h10, -1, 2'b01, 1'b0, -1, w);
    repeat (3) begin
      tick();
      check("no_regrant0", {ack0, ack1, busy}, 0);
    end

    // Reader skips address 100: error reported, next transaction clean.
    sector1 = 32'h2345; req1 = 1'b1;
    do_txn(1, 32'h2345, 100, 2'b10, 1'b1, -1, w);
    sector0 = 32'h77; req0 = 1'b1;
    do_txn(0, 32'h77, -1, 2'b01, 1'b0, -1, w);

    // Stray reader activity while idle is ignored.
    rd_done = 1'b1; rd_rvalid = 1'b1; rd_raddr = 9'd0; rd_rdata = 8'h55;
    repeat (2) begin
      tick();
      check("spur_pulses", {done0, done1, err0, err1, rvalid0, rvalid1, ack0, ack1}, 0);
      check("spur_busy", {busy, rd_start}, 0);
      check("spur_state", fsm_state, 0);
    end
    rd_done = 1'b0; rd_rvalid = 1'b0;

    // Both requesting from reset: 0,1,0,1 with minimum spacing (GAP + one IDLE cycle).
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sector0 = 32'h100; sector1 = 32'h200;
    req0 = 1'b1; req1 = 1'b1;
    do_txn(0, 32'h100, -1, 2'b00, 1'b0, -1, w);
    do_txn(1, 32'h200, -1, 2'b00, 1'b0, -1, w);
    check("spacing_01", w, 1);
    do_txn(0, 32'h100, -1, 2'b00, 1'b0, -1, w);
    check("spacing_10", w, 1);
    do_txn(1, 32'h200, -1, 2'b11, 1'b0, -1, w);
    check("spacing_01b", w, 1);
    tick();
    check("alt_quiet", {ack0, ack1, busy}, 0);

    // Reset mid-transaction at beat 200, then sole requester 1 still wins.
    sector0 = 32'h300; req0 = 1'b1;
    do_txn(0, 32'h300, -1, 2'b01, 1'b0, 200, w);
    tick();
    check_quiet("after_abort");
    sector1 = 32'h400; req1 = 1'b1;
    do_txn(1, 32'h400, -1, 2'b10, 1'b0, -1, w);

    // Requester 1 drops its request right after ack: completes, no re-grant.
    sector1 = 32'h500; req1 = 1'b1;
    do_txn(1, 32'h500, -1, 2'b10, 1'b0, -1, w);
    repeat (4) begin
      tick();
      check("no_regrant1", {ack0, ack1, busy, done0, done1}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_sector_arbiter.md
SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter SECTOR_W, default 32, sector address width.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports req0/req1  input  1  level read request from requester 0/1.
REQ-005 SHALL have ports sector0/sector1  input  SECTOR_W  sector number; sampled at grant.
REQ-006 SHALL have ports ack0/ack1  output  1  one-cycle pulse; request accepted.
REQ-007 SHALL have ports done0/done1  output  1  one-cycle pulse; transaction finished.
REQ-008 SHALL have ports err0/err1  output  1  valid with doneN; byte-stream check failed.
REQ-009 SHALL have ports rvalid0/rvalid1  output  1  routed data beat valid.
REQ-010 SHALL have ports raddr0/raddr1  output  9  routed byte index.
REQ-011 SHALL have ports rdata0/rdata1  output  8  routed byte.
REQ-012 SHALL have port rd_start  output  1  start to sector reader; held high until rd_done.
REQ-013 SHALL have port rd_sector_no  output  SECTOR_W  sector to reader.
REQ-014 SHALL have port rd_done  input  1  reader completion pulse.
REQ-015 SHALL have ports rd_rvalid  input  1, rd_raddr  input  9, rd_rdata  input  8  reader byte stream.
REQ-016 SHALL have ports busy  output  1  transaction in flight; owner  output  1  current grantee.

Function
REQ-017 SHALL implement FSM states IDLE, BUSY, GAP.
REQ-018 IDLE: no req -> stay; any req -> BUSY next cycle, latch grantee into owner, latch its sector into rd_sector_no, pulse ackN for that cycle.
REQ-019 Arbitration: single requester wins; both -> requester != last_served; last_served updated on each grant.
REQ-020 BUSY: rd_start=1, busy=1; rd_sector_no stable for whole transaction.
REQ-021 BUSY: each rd_rvalid beat forwarded to owner's rvalid/raddr/rdata with exactly 1 cycle registered latency; non-owner rvalid stays 0.
REQ-022 BUSY: 10-bit beat counter cleared at grant; each beat compares rd_raddr to counter; mismatch sets sticky error flag; counter increments per beat.
REQ-023 rd_done in BUSY -> GAP; owner's doneN pulses 1 cycle after rd_done (aligned with last forwarded beat); errN=1 if sticky error set or beat count !=512 including a beat coincident with rd_done.
REQ-024 GAP: rd_start=0, busy=1 for exactly 1 cycle, then IDLE; guarantees reader sees start deassert.
REQ-025 rd_done or rd_rvalid in IDLE/GAP SHALL be ignored (no forwarding, no done).
REQ-026 reqN deasserted during BUSY SHALL not abort; transaction completes, doneN still pulses.
REQ-027 reqN still high when returning to IDLE SHALL be treated as a new request.
REQ-028 Minimum grant-to-grant spacing SHALL be BUSY duration + 1 GAP + 1 IDLE cycle.
REQ-029 errN SHALL be 0 whenever doneN is 0.

Reset
REQ-030 rst_n low SHALL force IDLE, rd_start=0, rd_sector_no=0, busy=0, owner=0, last_served=1, all ackN/doneN/errN/rvalidN=0, raddrN=0, rdataN=0, counter and error flag cleared.
REQ-031 Reset asserted mid-BUSY SHALL abandon the transaction with no doneN pulse.

Verification
REQ-032 req0=1, sector0=0x10; reader returns 512 beats raddr 0..511, rd_done -> ack0 one pulse, rd_sector_no=0x10, rvalid0 512 beats delayed 1 cycle, done0 pulse, err0=0, rvalid1 never set.
REQ-033 req0, req1 asserted same cycle from reset, held -> grants alternate 0,1,0,1; ack order matches; rd_start low exactly 1 cycle between transactions.
REQ-034 Reader skips raddr 100 (511 beats) -> done pulse with err=1; next transaction err=0.
REQ-035 Spurious rd_done and rd_rvalid while IDLE -> no done, no rvalid, state stays IDLE.
REQ-036 rst_n pulsed low mid-BUSY at beat 200 -> all outputs 0 immediately; no doneN; next req1 granted (last_served=1 rule does not block sole requester).
REQ-037 req1 dropped 1 cycle after ack1 -> transaction completes, done1 pulses, no re-grant.
